// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner of the shared sysbus with a one-cycle
// turnaround between tenures and revocation of tenures that run past MAX_HOLD.
module sysbus_arbiter #(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 3,
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     bus_busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     timeout_err,
  output logic [N_REQ-1:0]         penalised
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_pen;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_last;
  logic [HW-1:0]    r_hold;
  logic             r_timeout;
  logic [N_REQ-1:0] w_elig;
  logic [OW-1:0]    w_win;
  logic             w_owner_req;
  logic             w_expire;
  if (WORD_W < 1 || OP_W < 1 || N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("sysbus_arbiter: parameter out of range");
  end
  assign w_elig      = req & ~r_pen;
  assign w_owner_req = req[r_owner];
  assign w_expire    = r_hold == HW'(MAX_HOLD);
  // Scan downward so the candidate closest after last_owner is assigned last and wins.
  always_comb begin
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(r_last) + 1 + k;
      j = j >= N_REQ ? j - N_REQ : j;
      w_win = w_elig[j] ? OW'(j) : w_win;
    end
  end
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_pen     <= '0;
      r_owner   <= '0;
      r_last    <= OW'(N_REQ - 1);
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_pen     <= r_pen & req;
      case (r_state)
        IDLE: if (|w_elig) begin
          r_grant <= N_REQ'(1) << w_win;
          r_owner <= w_win;
          r_last  <= w_win;
          r_hold  <= HW'(1);
          r_state <= OWN;
        end
        OWN: if (!w_owner_req || w_expire) begin
          r_grant   <= '0;
          r_owner   <= '0;
          r_hold    <= '0;
          r_state   <= TURN;
          r_timeout <= w_owner_req;
          if (w_owner_req) r_pen[r_owner] <= 1'b1;
        end else begin
          r_hold <= r_hold + HW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign grant       = r_grant;
  assign bus_busy    = |r_grant;
  assign owner       = r_owner;
  assign timeout_err = r_timeout;
  assign penalised   = r_pen;
  a_grant_onehot: assert property (@(posedge clock) disable iff (!n_reset) $onehot0(r_grant));
  a_turn_quiet:   assert property (@(posedge clock) disable iff (!n_reset) r_state == TURN |-> r_grant == '0);
  a_to_pulse:     assert property (@(posedge clock) disable iff (!n_reset) r_timeout |=> !r_timeout);
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed and random stimulus against a behavioural arbiter
// model, compared on every clock, plus hand-computed checks for the key scenarios.
module tb_sysbus_arbiter;
  localparam int N    = 3;
  localparam int MAXH = 8;
  logic         clock   = 1'b0;
  logic         n_reset = 1'b0;
  logic [N-1:0] req     = '0;
  logic [N-1:0] grant;
  logic [N-1:0] penalised;
  logic         bus_busy;
  logic         timeout_err;
  logic [1:0]   owner;
  int vectors     = 0;
  int miscompares = 0;
  // model: 0 = no owner, 1 = owned, 2 = turnaround
  int m_state = 0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_hold  = 0;
  int m_to    = 0;
  int m_pen[N];

  sysbus_arbiter #(.WORD_W(8), .OP_W(3), .N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clock(clock), .n_reset(n_reset), .req(req), .grant(grant), .bus_busy(bus_busy),
    .owner(owner), .timeout_err(timeout_err), .penalised(penalised)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_state = 0; m_owner = 0; m_last = N - 1; m_hold = 0; m_to = 0;
    for (int i = 0; i < N; i++) m_pen[i] = 0;
  endfunction

  function automatic void m_step(input logic [N-1:0] r);
    m_to = 0;
    for (int i = 0; i < N; i++) if (!r[i]) m_pen[i] = 0;
    if (m_state == 0) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (m_state == 0 && r[c] && m_pen[c] == 0) begin
          m_state = 1; m_owner = c; m_last = c; m_hold = 1;
        end
      end
    end else if (m_state == 1) begin
      if (!r[m_owner]) m_state = 2;
      else if (m_hold == MAXH) begin
        m_state = 2; m_to = 1; m_pen[m_owner] = 1;
      end else m_hold++;
    end else m_state = 0;
  endfunction

  always @(posedge clock) begin
    logic [N-1:0] r;
    int eg, ep;
    r = req;
    if (!n_reset) m_reset();
    else m_step(r);
    eg = (m_state == 1) ? (1 << m_owner) : 0;
    ep = 0;
    for (int i = 0; i < N; i++) ep |= m_pen[i] << i;
    #1;
    check("model_grant", 32'(grant), eg);
    check("model_owner", 32'(owner), (m_state == 1) ? m_owner : 0);
    check("model_busy", 32'(bus_busy), (eg != 0) ? 1 : 0);
    check("model_timeout", 32'(timeout_err), m_to);
    check("model_penalised", 32'(penalised), ep);
    check("grant_onehot0", 32'($onehot0(grant)), 1);
  end

  task automatic do_reset();
    req = '0;
    n_reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  initial begin
    int exp_seq[4] = '{1, 2, 4, 1};
    int g, to;
    m_reset();
    repeat (2) @(negedge clock);
    check("rst_grant", 32'(grant), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_penalised", 32'(penalised), 0);
    n_reset = 1'b1;
    // single master, voluntary release
    req = 3'b001;
    @(negedge clock);
    check("t1_grant_c1", 32'(grant), 1);
    check("t1_busy_c1", 32'(bus_busy), 1);
    check("t1_owner", 32'(owner), 0);
    repeat (3) @(negedge clock);
    check("t1_grant_c4", 32'(grant), 1);
    req = 3'b000;
    @(negedge clock);
    check("t1_grant_turn", 32'(grant), 0);
    check("t1_busy_turn", 32'(bus_busy), 0);
    check("t1_timeout", 32'(timeout_err), 0);
    // rotation with all masters requesting
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t2_grant_c1", 32'(grant), exp_seq[i]);
      @(negedge clock);
      check("t2_grant_c2", 32'(grant), exp_seq[i]);
      req = 3'(7 & ~exp_seq[i]);
      @(negedge clock);
      check("t2_gap1", 32'(grant), 0);
      req = 3'b111;
      @(negedge clock);
      check("t2_gap2", 32'(grant), 0);
    end
    // tenure timeout and penalty
    do_reset();
    req = 3'b010;
    g = 0;
    to = 0;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clock);
      if (grant == 3'b010) g++;
      if (timeout_err) to++;
      if (s == 9) check("t3_timeout_first_turn", 32'(timeout_err), 1);
    end
    check("t3_grant_cycles", g, 8);
    check("t3_timeout_pulses", to, 1);
    check("t3_penalised", 32'(penalised), 2);
    req = 3'b000;
    @(negedge clock);
    check("t3_pen_cleared", 32'(penalised), 0);
    req = 3'b010;
    @(negedge clock);
    check("t3_regrant", 32'(grant), 2);
    // requests arriving mid-tenure
    do_reset();
    req = 3'b001;
    repeat (2) @(negedge clock);
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t4_hold_owner0", 32'(grant), 1);
    end
    req = 3'b110;
    @(negedge clock);
    check("t4_gap1", 32'(grant), 0);
    @(negedge clock);
    check("t4_gap2", 32'(grant), 0);
    @(negedge clock);
    check("t4_next_owner", 32'(grant), 2);
    // asynchronous reset mid-tenure
    do_reset();
    req = 3'b100;
    repeat (5) @(negedge clock);
    check("t5_grant_before", 32'(grant), 4);
    #2 n_reset = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 0);
    check("t5_async_busy", 32'(bus_busy), 0);
    check("t5_async_pen", 32'(penalised), 0);
    check("t5_async_timeout", 32'(timeout_err), 0);
    @(negedge clock);
    n_reset = 1'b1;
    check("t5_grant_released", 32'(grant), 0);
    @(negedge clock);
    check("t5_first_grant", 32'(grant), 4);
    // release and new request in the same cycle
    do_reset();
    req = 3'b001;
    repeat (2) @(negedge clock);
    req = 3'b010;
    @(negedge clock);
    check("t6_turn", 32'(grant), 0);
    @(negedge clock);
    check("t6_idle", 32'(grant), 0);
    @(negedge clock);
    check("t6_new_grant", 32'(grant), 2);
    // random request traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 399) == 0) begin
        #2 n_reset = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
      end
    end
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
